// File: rtl/uart_tx_pkg.sv
// Shared types and mux-select encoding for the UART transmit frame sequencer.
// UART_TX_TWO_STOP_EN adds the STOP2 state for two stop bits per frame.
package uart_tx_pkg;

  // TX output mux select; the mux input wiring follows these values.
  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
    STOP   = 3'd4,
    STOP2  = 3'd5
`else
    STOP   = 3'd4
`endif
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer: drives serializer load/shift and the output mux select.
// Define UART_TX_TWO_STOP_EN to emit two stop bits per frame.
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       ser_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_en_q, par_en_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    unique case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          state_d  = START;
          par_en_d = PAR_EN;
        end
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: begin
        // Counter parks on the last bit so it never exceeds DATA_WIDTH-1.
        if (bit_cnt_q == CNT_LAST) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP: begin
        state_d = STOP2;
      end
      STOP2: begin
        if (Data_Valid) begin
          state_d  = START;
          par_en_d = PAR_EN;
        end else begin
          state_d = IDLE;
        end
      end
`else
      STOP: begin
        // Back-to-back frames skip IDLE entirely.
        if (Data_Valid) begin
          state_d  = START;
          par_en_d = PAR_EN;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ser_load = 1'b0;
    ser_en   = 1'b0;
    busy     = 1'b0;
    mux_sel  = SEL_STOP;
    unique case (state_q)
      IDLE: begin
        mux_sel = SEL_STOP;
      end
      START: begin
        mux_sel  = SEL_START;
        busy     = 1'b1;
        ser_load = 1'b1;
      end
      DATA: begin
        mux_sel = SEL_DATA;
        busy    = 1'b1;
        ser_en  = 1'b1;
      end
      PARITY: begin
        mux_sel = SEL_PAR;
        busy    = 1'b1;
      end
      STOP: begin
        mux_sel = SEL_STOP;
        busy    = 1'b1;
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP2: begin
        mux_sel = SEL_STOP;
        busy    = 1'b1;
      end
`endif
      default: begin
        mux_sel = SEL_STOP;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- Frame sequencer for the UART transmit path.
- Drives the 2-bit select of the registered TX output mux and the serializer enables (load/shift) from a single FSM.
- Tracks data bits with an internal bit counter and runs one bit per CLK; CLK is the TX baud clock.
- Sits between the upstream data source (Data_Valid handshake) and the serializer, parity calculator and TX output mux.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (legal range 5..9).

Ports:
- CLK        input   1    TX baud clock; all state updates on posedge.
- RST        input   1    asynchronous active-low reset.
- Data_Valid input   1    upstream frame request; payload is held stable by upstream until busy rises.
- PAR_EN     input   1    parity bit enable; sampled only on frame accept.
- ser_load   output  1    serializer parallel-load strobe.
- ser_en     output  1    serializer shift enable, one bit per cycle.
- mux_sel    output  2    TX output mux select (encoding in package).
- busy       output  1    frame in progress.

Behaviour:
- Reset is asynchronous, active-low.
  - Reset values: state=IDLE, bit_cnt=0, par_en_q=0.
  - Outputs during reset: ser_load=0, ser_en=0, busy=0, mux_sel=SEL_STOP (line idles high).
- Outputs are Moore-decoded from the state register (no input-to-output combinational paths):
  - IDLE: mux_sel=SEL_STOP, busy=0.
  - START: mux_sel=SEL_START, busy=1, ser_load=1.
  - DATA: mux_sel=SEL_DATA, busy=1, ser_en=1.
  - PARITY: mux_sel=SEL_PAR, busy=1.
  - STOP: mux_sel=SEL_STOP, busy=1.
  - Any output not listed for a state is 0.
- Transitions:
  - IDLE -> START when Data_Valid=1. On that edge, par_en_q <= PAR_EN.
  - START -> DATA unconditionally; bit_cnt <= 0.
  - DATA: bit_cnt increments each cycle. At bit_cnt==DATA_WIDTH-1, go to PARITY if par_en_q, else STOP.
  - PARITY -> STOP unconditionally.
  - STOP -> START if Data_Valid=1 (back-to-back frame, no idle gap; par_en_q re-sampled). Otherwise STOP -> IDLE.
- Data_Valid in START/DATA/PARITY is ignored and not queued. Upstream must hold it, or re-assert it, by the STOP cycle.
- A PAR_EN change mid-frame has no effect on the current frame.
- Frame length in cycles: 1 + DATA_WIDTH + par_en_q + 1. busy is high for exactly that many consecutive cycles.
- bit_cnt width is $clog2(DATA_WIDTH). bit_cnt never exceeds DATA_WIDTH-1 and holds its value outside DATA.
- Reset mid-frame aborts immediately: state returns to IDLE, outputs take reset values, and there is no partial stop bit.
- Illegal or unreachable state encodings recover to IDLE on the next edge.
- The mux is registered, so the serial line lags mux_sel by one CLK. This is accounted for at system level, not here.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined:
  - Adds state STOP2, also decoded as mux_sel=SEL_STOP, busy=1.
  - Transitions become STOP -> STOP2 unconditionally; STOP2 -> START/IDLE using the same rule as single-stop.
  - Frame length is one cycle longer.
- Undefined: single stop bit; STOP2 does not exist in the state type.

Decomposition:
- Package uart_tx_pkg:
  - Enum typedef tx_state_e: IDLE, START, DATA, PARITY, STOP, and STOP2 (present under the macro).
  - Select constants: SEL_START=2'b00, SEL_STOP=2'b01, SEL_DATA=2'b10, SEL_PAR=2'b11. The mux input wiring follows these constants.
- No sub-module; the bit counter is inline.

Test Plan:
- Reset, DATA_WIDTH=8, PAR_EN=0, single Data_Valid pulse:
  - busy high 10 cycles; mux_sel sequence = 00, 10×8, 01, then idle 01.
  - ser_load high 1 cycle (START); ser_en high 8 cycles.
- PAR_EN=1 at accept, then PAR_EN=0 during DATA: frame is 11 cycles and SEL_PAR appears once after the 8th data bit.
- Data_Valid held continuously for 3 frames (PAR_EN=0): busy stays high 30 cycles; STOP goes directly to START with no IDLE cycle.
- Data_Valid pulsed during DATA only, low at STOP: the pulse is ignored; return to IDLE after the current frame.
- RST asserted at the 4th data bit:
  - busy=0, ser_en=0 and mux_sel=01 immediately (asynchronous).
  - After release with Data_Valid=0, the block stays IDLE.
- UART_TX_TWO_STOP_EN defined, PAR_EN=1: frame is 12 cycles with two consecutive SEL_STOP cycles before the next START.
